// File: rtl/fabric_load_arb_pkg.sv
// Shared types and constants for the fabric load arbiter.
package fabric_load_arb_pkg;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_STRAY_RSP = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issue_state_t;

endpackage

// File: rtl/fabric_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping at NUM_REQ-1.
module fabric_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_grant
);

  logic [2*NUM_REQ-1:0] rotated;
  logic                 found;
  int unsigned          sum;

  // Rotate so that bit 0 is the requester at ptr, then take the lowest set bit.
  always_comb begin
    rotated = {req, req} >> ptr;
    found   = 1'b0;
    sum     = 0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && rotated[j]) begin
        found = 1'b1;
        sum   = 32'(ptr) + j;
      end
    end
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    winner    = ID_W'(sum);
    any_grant = enable && found;
    grant     = '0;
    if (any_grant) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/fabric_load_arbiter.sv
// Shares one in-order memory load port between NUM_REQ load PEs.
// Optional error reporting enabled by defining FABRIC_LOAD_ARB_ERR_EN.
module fabric_load_arbiter
  import fabric_load_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned ELEM_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic                          mem_addr_valid,
  input  logic                          mem_addr_ready,
  output logic [ADDR_WIDTH-1:0]         mem_addr_data,
  input  logic                          mem_data_valid,
  output logic                          mem_data_ready,
  input  logic [ELEM_WIDTH-1:0]         mem_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [ELEM_WIDTH-1:0]         rsp_data,
  output logic                          busy
`ifdef FABRIC_LOAD_ARB_ERR_EN
  ,
  output logic                          err_valid,
  output logic [1:0]                    err_code
`endif
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  issue_state_t          state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       head;
  logic [NUM_REQ-1:0]    grant;
  logic                  any_grant;
  logic                  capture_ok;
  logic                  push;
  logic                  pop;
  logic                  nonempty;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [ID_W-1:0]       id_mem [MAX_OUTSTANDING];

  // Slot is reserved at capture; count compared before this cycle's pop.
  assign capture_ok = !rst && (count < CNT_W'(MAX_OUTSTANDING)) &&
                      ((state == IDLE) || mem_addr_ready);

  fabric_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .enable    (capture_ok),
    .ptr       (rr_ptr),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  assign req_ready      = grant;
  assign push           = any_grant;
  assign sel_addr       = req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_addr_valid = (state == ISSUE);
  assign nonempty       = (count != '0);
  assign head           = id_mem[rd_ptr];
  assign rsp_data       = mem_data;
  assign busy           = nonempty || (state == ISSUE);
  assign pop            = mem_data_valid && mem_data_ready && nonempty;

`ifdef FABRIC_LOAD_ARB_ERR_EN
  // Stray responses on an empty FIFO are drained so the memory cannot lock up.
  assign mem_data_ready = !rst && (nonempty ? rsp_ready[head] : 1'b1);
`else
  assign mem_data_ready = nonempty && rsp_ready[head];
`endif

  always_comb begin
    rsp_valid = '0;
    if (mem_data_valid && nonempty) rsp_valid[head] = 1'b1;
  end

  // Issue register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mem_addr_data <= '0;
      rr_ptr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_grant) state <= ISSUE;
        end
        ISSUE: begin
          if (mem_addr_ready && !any_grant) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (any_grant) begin
        mem_addr_data <= sel_addr;
        rr_ptr        <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
      end
    end
  end

  // ID FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= winner;
  end

`ifdef FABRIC_LOAD_ARB_ERR_EN
  // Sticky error: first event wins until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (!err_valid) begin
      if (mem_data_valid && !nonempty) begin
        err_valid <= 1'b1;
        err_code  <= ERR_STRAY_RSP;
      end else if (push && !pop && (count == CNT_W'(MAX_OUTSTANDING))) begin
        err_valid <= 1'b1;
        err_code  <= ERR_OVERFLOW;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fabric_load_arbiter.sv
// Directed self-checking bench for fabric_load_arbiter (default parameters).
module tb_fabric_load_arbiter;

  localparam int unsigned NUM_REQ         = 4;
  localparam int unsigned ADDR_WIDTH      = 64;
  localparam int unsigned ELEM_WIDTH      = 32;
  localparam int unsigned MAX_OUTSTANDING = 8;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic                          mem_addr_valid;
  logic                          mem_addr_ready;
  logic [ADDR_WIDTH-1:0]         mem_addr_data;
  logic                          mem_data_valid;
  logic                          mem_data_ready;
  logic [ELEM_WIDTH-1:0]         mem_data;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [ELEM_WIDTH-1:0]         rsp_data;
  logic                          busy;
`ifdef FABRIC_LOAD_ARB_ERR_EN
  logic                          err_valid;
  logic [1:0]                    err_code;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fabric_load_arbiter #(
    .NUM_REQ         (NUM_REQ),
    .ADDR_WIDTH      (ADDR_WIDTH),
    .ELEM_WIDTH      (ELEM_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .mem_addr_valid (mem_addr_valid),
    .mem_addr_ready (mem_addr_ready),
    .mem_addr_data  (mem_addr_data),
    .mem_data_valid (mem_data_valid),
    .mem_data_ready (mem_data_ready),
    .mem_data       (mem_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .busy           (busy)
`ifdef FABRIC_LOAD_ARB_ERR_EN
    ,
    .err_valid      (err_valid),
    .err_code       (err_code)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] addrs [4];
    addrs[0] = 64'hA000;
    addrs[1] = 64'hA100;
    addrs[2] = 64'hA200;
    addrs[3] = 64'hA300;

    rst            = 1'b1;
    req_valid      = '0;
    req_addr       = '0;
    mem_addr_ready = 1'b0;
    mem_data_valid = 1'b0;
    mem_data       = '0;
    rsp_ready      = '0;
    #1;
    chk("rst_mem_addr_valid", 64'(mem_addr_valid), 64'd0);
    chk("rst_mem_addr_data",  mem_addr_data,       64'd0);
    chk("rst_req_ready",      64'(req_ready),      64'd0);
    chk("rst_busy",           64'(busy),           64'd0);
    chk("rst_mem_data_ready", 64'(mem_data_ready), 64'd0);
    chk("rst_rsp_valid",      64'(rsp_valid),      64'd0);
    repeat (2) tick();
    rst = 1'b0;

    // Single requester 2.
    req_valid = 4'b0100;
    req_addr[2*ADDR_WIDTH +: ADDR_WIDTH] = 64'h1000;
    mem_addr_ready = 1'b1;
    #1;
    chk("single_req_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    #1;
    chk("single_addr_valid", 64'(mem_addr_valid), 64'd1);
    chk("single_addr_data",  mem_addr_data,       64'h1000);
    chk("single_busy",       64'(busy),           64'd1);
    tick();
    chk("single_idle", 64'(mem_addr_valid), 64'd0);
    mem_data_valid = 1'b1;
    mem_data       = 32'hDEAD;
    rsp_ready      = 4'b1111;
    #1;
    chk("single_rsp_valid", 64'(rsp_valid),      64'b0100);
    chk("single_rsp_data",  64'(rsp_data),       64'hDEAD);
    chk("single_mdr",       64'(mem_data_ready), 64'd1);
    tick();
    mem_data_valid = 1'b0;
    #1;
    chk("single_busy_done", 64'(busy), 64'd0);

    // Fairness from a fresh pointer.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addrs[i];
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("fair_grant%0d", k), 64'(req_ready), 64'(1) << (k % 4));
      tick();
      chk($sformatf("fair_addr%0d", k), mem_addr_data, addrs[k % 4]);
    end
    req_valid = '0;
    tick();
    chk("fair_idle", 64'(mem_addr_valid), 64'd0);
    mem_data_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mem_data = 32'h5000 + 32'(k);
      #1;
      chk($sformatf("fair_rsp%0d", k), 64'(rsp_valid), 64'(1) << (k % 4));
      chk($sformatf("fair_rdata%0d", k), 64'(rsp_data), 64'h5000 + 64'(k));
      tick();
    end
    mem_data_valid = 1'b0;
    #1;
    chk("fair_busy_done", 64'(busy), 64'd0);

    // Address backpressure: rr pointer is 1, so requester 3 wins first.
    mem_addr_ready = 1'b0;
    req_valid = 4'b1000;
    req_addr[3*ADDR_WIDTH +: ADDR_WIDTH] = 64'h3333;
    req_addr[1*ADDR_WIDTH +: ADDR_WIDTH] = 64'h1111;
    #1;
    chk("bp_first_grant", 64'(req_ready), 64'b1000);
    tick();
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_hold_ready%0d", k), 64'(req_ready), 64'd0);
      chk($sformatf("bp_hold_addr%0d", k), mem_addr_data, 64'h3333);
      chk($sformatf("bp_hold_valid%0d", k), 64'(mem_addr_valid), 64'd1);
      tick();
    end
    mem_addr_ready = 1'b1;
    #1;
    chk("bp_release_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    #1;
    chk("bp_next_addr", mem_addr_data, 64'h1111);
    tick();

    // Drain head 3, then stall head 1 while only requester 3 is ready.
    mem_data_valid = 1'b1;
    rsp_ready = 4'b1111;
    #1;
    chk("rbp_head3", 64'(rsp_valid), 64'b1000);
    tick();
    rsp_ready = 4'b1000;
    #1;
    chk("rbp_mdr_low",  64'(mem_data_ready), 64'd0);
    chk("rbp_rsp_held", 64'(rsp_valid),      64'b0010);
    tick();
    chk("rbp_rsp_held2", 64'(rsp_valid), 64'b0010);
    rsp_ready = 4'b0010;
    #1;
    chk("rbp_mdr_high", 64'(mem_data_ready), 64'd1);
    tick();
    mem_data_valid = 1'b0;
    #1;
    chk("rbp_busy_done", 64'(busy), 64'd0);

    // Full FIFO: rr pointer is 2; eight grants then refusal.
    rsp_ready = 4'b1111;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("full_grant%0d", k), 64'(req_ready), 64'(1) << ((2 + k) % 4));
      tick();
    end
    chk("full_refuse", 64'(req_ready), 64'd0);
    tick();
    chk("full_refuse_idle", 64'(req_ready),      64'd0);
    chk("full_idle",        64'(mem_addr_valid), 64'd0);
    mem_data_valid = 1'b1;
    #1;
    chk("full_pop_head",   64'(rsp_valid), 64'b0100);
    chk("full_pop_refuse", 64'(req_ready), 64'd0);
    tick();
    mem_data_valid = 1'b0;
    #1;
    chk("full_regrant", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    #1;
    chk("full_refill_refuse", 64'(req_ready), 64'd0);

    // Async reset mid-burst with three outstanding.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    req_valid = 4'b0111;
    repeat (3) tick();
    chk("mid_busy_pre", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(mem_addr_valid), 64'd0);
    chk("mid_rst_data",  mem_addr_data,       64'd0);
    chk("mid_rst_busy",  64'(busy),           64'd0);
    chk("mid_rst_ready", 64'(req_ready),      64'd0);
    req_valid = 4'b1111;
    rst = 1'b0;
    #1;
    chk("mid_rr_zero", 64'(req_ready), 64'b0001);
    req_valid = '0;
    mem_data_valid = 1'b1;
    #1;
    chk("stray_rsp_valid", 64'(rsp_valid), 64'd0);
`ifdef FABRIC_LOAD_ARB_ERR_EN
    chk("stray_mdr", 64'(mem_data_ready), 64'd1);
    tick();
    chk("stray_err_valid", 64'(err_valid), 64'd1);
    chk("stray_err_code",  64'(err_code),  64'd1);
`else
    chk("stray_mdr", 64'(mem_data_ready), 64'd0);
    tick();
    chk("stray_busy", 64'(busy), 64'd0);
`endif
    mem_data_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fabric_load_arbiter.md
Name: fabric_load_arbiter

Overview:
- Shares one memory load port between NUM_REQ load PEs.
- Round-robin arbitration over address requests; a registered issue stage drives the memory address channel.
- An in-order ID FIFO records the grant order and routes each memory response back to the requester that issued it.
- Sits between the load PEs' out0/in1 ports and a single memory read interface. The memory returns data strictly in request order.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- ADDR_WIDTH, 64: address width in bits.
- ELEM_WIDTH, 32: response data width in bits.
- MAX_OUTSTANDING, 8: ID FIFO depth (power of two, ≥2). Bounds the number of captured-but-unanswered requests.
- ID_W, localparam, $clog2(NUM_REQ).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester address valid.
- req_ready  out  NUM_REQ  per-requester address accept.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies [i*ADDR_WIDTH +: ADDR_WIDTH].
- mem_addr_valid  out  1  issue register occupied.
- mem_addr_ready  in  1  memory accepts address.
- mem_addr_data  out  ADDR_WIDTH  registered address.
- mem_data_valid  in  1  memory response valid.
- mem_data_ready  out  1  response accept.
- mem_data  in  ELEM_WIDTH  response data.
- rsp_valid  out  NUM_REQ  per-requester response valid.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_data  out  ELEM_WIDTH  response data, shared by all requesters.
- busy  out  1  ID FIFO non-empty or issue register occupied.

Behaviour:
- Reset values:
  - Outputs: all valid/ready outputs 0, mem_addr_data 0, busy 0.
  - Internal: rr pointer 0, FIFO rd/wr pointers and count 0, issue state IDLE.
- Issue FSM, two states:
  - IDLE: issue register empty.
  - ISSUE: mem_addr_valid=1, mem_addr_data held stable until mem_addr_ready.
- Capture condition: capture_ok = FIFO count < MAX_OUTSTANDING, and either state==IDLE or (state==ISSUE && mem_addr_ready).
- Grant:
  - When capture_ok, the round-robin arbiter picks the first asserted req_valid at or after rr pointer, wrapping at NUM_REQ-1 → 0.
  - req_ready[winner]=1 in the same cycle, combinationally. All other req_ready are 0.
- On grant:
  - Capture req_addr[winner] into the issue register.
  - Push winner ID into the FIFO.
  - rr pointer ← winner+1 mod NUM_REQ.
  - Next state ISSUE.
- On mem_addr_ready in ISSUE with no new grant → IDLE.
- Back-to-back issue: fire plus a new grant in the same cycle keeps state ISSUE. Sustained throughput is 1 address/cycle.
- Latency: req handshake → mem_addr_valid is 1 cycle.
- FIFO slot reservation:
  - The slot is reserved at capture, not at memory acceptance.
  - In-order memory guarantees the head ID matches the next response.
- Full FIFO:
  - No grant; all req_ready=0.
  - Simultaneous pop and full: the grant is still refused that cycle (count compared pre-update).
- Response routing:
  - head = FIFO[rd_ptr].
  - rsp_valid[head] = mem_data_valid && count>0; all other rsp_valid are 0.
  - rsp_data = mem_data.
  - mem_data_ready = count>0 && rsp_ready[head].
  - Pop on mem_data_valid && mem_data_ready.
  - Path is combinational, zero latency.
- Simultaneous push and pop: count unchanged; both pointers advance and wrap at MAX_OUTSTANDING.
- Empty FIFO with mem_data_valid (protocol violation): see optional feature.
- Reset mid-operation: all in-flight state is discarded immediately and asynchronously. Outstanding memory responses are the environment's responsibility.

Optional Feature:
- Macro: FABRIC_LOAD_ARB_ERR_EN.
- Defined:
  - Adds output err_valid (1) and err_code (2).
  - A response arriving on an empty FIFO is drained (mem_data_ready=1) and sets sticky err_valid=1, err_code=2'd1.
  - FIFO count overflow attempt (should be impossible) sets err_code=2'd2.
  - Cleared only by rst.
- Undefined:
  - Ports absent.
  - Empty-FIFO responses stall (mem_data_ready=0).

Decomposition:
- Package fabric_load_arb_pkg holds:
  - err code constants ERR_NONE=0, ERR_STRAY_RSP=1, ERR_OVERFLOW=2;
  - the issue-state enum {IDLE, ISSUE}.
- Sub-module fabric_rr_arbiter (NUM_REQ):
  - inputs: req vector, enable, pointer;
  - outputs: one-hot grant, encoded winner, any_grant.
  - Reusable by store arbitration.

Test Plan:
- Single requester: req_valid=4'b0100, addr=0x1000, mem_addr_ready=1 → mem_addr_valid next cycle with 0x1000. Response 0xDEAD appears on rsp_valid[2] with data 0xDEAD.
- Fairness: all four req_valid held high, mem always ready → grants in order 0,1,2,3,0, one per cycle. Responses are routed to 0,1,2,3,0 in that order.
- Backpressure: mem_addr_ready=0 for 5 cycles → mem_addr_data stable and req_ready all 0 while ISSUE is held. The pending grant issues on the ready cycle.
- Full FIFO: MAX_OUTSTANDING=8, no responses, 9 requests → 8 captured, req_ready=0 afterwards. One response popped → one further grant the following cycle.
- Response backpressure: head=1 with rsp_ready[1]=0 → mem_data_ready=0 and rsp_valid[1]=1 held; rsp_ready[3]=1 has no effect.
- Async reset asserted mid-burst with 3 outstanding → outputs 0 immediately, count 0, rr pointer 0. With FABRIC_LOAD_ARB_ERR_EN, a stray response then gives err_valid=1, err_code=1.
